// File: rtl/spi_fifo_lvl.sv
// Synchronous FIFO with level count, almost-full/empty thresholds and sticky error flags.
// Define SPI_FIFO_FWFT_EN for first-word-fall-through read data; default is a registered read.
module spi_fifo_lvl #(
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                         i_clk,
  input  logic                         flush,
  input  logic                         buff_WEn,
  input  logic                         buff_REn,
  input  logic [DWIDTH-1:0]            dataIn,
  input  logic                         clr_err,
  output logic [DWIDTH-1:0]            dataOut,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;

  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LW'(AF_LVL));
  assign almost_empty = (level_q <= LW'(AE_LVL));
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A write into a full FIFO is still accepted when a read frees the slot in the same edge.
  assign wr_acc = buff_WEn && (!full || buff_REn);
  assign rd_acc = buff_REn && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (rd_acc)
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (wr_acc && !rd_acc)
        level_d = level_q + LW'(1);
      else if (rd_acc && !wr_acc)
        level_d = level_q - LW'(1);
      // A new error event outranks a simultaneous clear.
      if (clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (buff_WEn && full && !buff_REn)
        ovf_d = 1'b1;
      if (buff_REn && empty)
        unf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
    ovf_q    <= ovf_d;
    unf_q    <= unf_d;
  end

  // Storage has no reset; flush only rewinds the pointers.
  always_ff @(posedge i_clk) begin
    if (!flush && wr_acc)
      mem_q[wr_ptr_q] <= dataIn;
  end

`ifdef SPI_FIFO_FWFT_EN
  assign dataOut = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [DWIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (flush)
      dout_d = '0;
    else if (rd_acc)
      dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_clk) begin
    dout_q <= dout_d;
  end

  assign dataOut = dout_q;
`endif

endmodule

// File: tb/tb_spi_fifo_lvl.sv
// Directed bench for spi_fifo_lvl: three instances (DEPTH 8, DEPTH 5, DEPTH 8 with AF 6 / AE 2)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_spi_fifo_lvl;

  logic       clk = 1'b0;
  logic       flush, we, re, clr;
  logic [7:0] din;

  logic [7:0] do8, do5, doa;
  logic       full8, empty8, af8, ae8, ovf8, unf8;
  logic       full5, empty5, af5, ae5, ovf5, unf5;
  logic       fulla, emptya, afa, aea, ovfa, unfa;
  logic [3:0] lvl8, lvla;
  logic [2:0] lvl5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_fifo_lvl #(.DEPTH(8), .DWIDTH(8)) u8 (
    .i_clk(clk), .flush(flush), .buff_WEn(we), .buff_REn(re), .dataIn(din), .clr_err(clr),
    .dataOut(do8), .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8),
    .level(lvl8), .overflow(ovf8), .underflow(unf8));

  spi_fifo_lvl #(.DEPTH(5), .DWIDTH(8)) u5 (
    .i_clk(clk), .flush(flush), .buff_WEn(we), .buff_REn(re), .dataIn(din), .clr_err(clr),
    .dataOut(do5), .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5),
    .level(lvl5), .overflow(ovf5), .underflow(unf5));

  spi_fifo_lvl #(.DEPTH(8), .DWIDTH(8), .AF_LVL(6), .AE_LVL(2)) ua (
    .i_clk(clk), .flush(flush), .buff_WEn(we), .buff_REn(re), .dataIn(din), .clr_err(clr),
    .dataOut(doa), .full(fulla), .empty(emptya), .almost_full(afa), .almost_empty(aea),
    .level(lvla), .overflow(ovfa), .underflow(unfa));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request pattern; inputs return to idle and outputs are settled on return.
  task automatic cyc(input logic f, input logic w, input logic r, input logic c, input logic [7:0] d);
    flush = f; we = w; re = r; clr = c; din = d;
    @(posedge clk);
    #1;
    flush = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; din = 8'h00;
  endtask

  task automatic pop(input bit c8, input bit c5, input bit ca, input logic [7:0] exp);
`ifdef SPI_FIFO_FWFT_EN
    if (c8) chk("rd_data_d8", do8, exp);
    if (c5) chk("rd_data_d5", do5, exp);
    if (ca) chk("rd_data_af", doa, exp);
    cyc(0, 0, 1, 0, 8'h00);
`else
    cyc(0, 0, 1, 0, 8'h00);
    if (c8) chk("rd_data_d8", do8, exp);
    if (c5) chk("rd_data_d5", do5, exp);
    if (ca) chk("rd_data_af", doa, exp);
`endif
  endtask

  initial begin
    logic [7:0] v;
    flush = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; din = 8'h00;
    #2;
    cyc(1, 0, 0, 0, 8'h00);

    // Reset state
    chk("rst_dout", do8, 8'h00);
    chk("rst_level", lvl8, 4'd0);
    chk("rst_empty", empty8, 1'b1);
    chk("rst_full", full8, 1'b0);
    chk("rst_af", af8, 1'b0);
    chk("rst_ae", ae8, 1'b1);
    chk("rst_ovf", ovf8, 1'b0);
    chk("rst_unf", unf8, 1'b0);
    chk("rst_d5_flags", {full5, empty5, af5, ae5, ovf5, unf5}, 6'b010100);
    chk("rst_af_flags", {fulla, emptya, ovfa, unfa}, 4'b0100);

    // Fill 0x01..0x08; thresholds on the AF=6/AE=2 instance; DEPTH 5 overflows on words 6..8
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 0, i[7:0]);
      chk("fill_level", lvl8, i);
      chk("thr_ae", aea, (i <= 2));
      chk("thr_af", afa, (i >= 6));
      chk("d8_af", af8, (i >= 7));
    end
    chk("fill_full", full8, 1'b1);
    chk("fill_full_af", fulla, 1'b1);
    chk("d5_fill_level", lvl5, 3'd5);
    chk("d5_fill_ovf", ovf5, 1'b1);
    chk("d8_no_ovf", ovf8, 1'b0);

    for (int i = 1; i <= 8; i++) begin
      pop(1, 0, 1, i[7:0]);
      if (i == 1) begin
        cyc(0, 0, 0, 0, 8'h00);
`ifdef SPI_FIFO_FWFT_EN
        chk("idle_head", do8, 8'h02);
`else
        chk("idle_hold", do8, 8'h01);
`endif
      end
    end
    chk("drain_empty", empty8, 1'b1);
    chk("drain_level", lvl8, 4'd0);

    // DEPTH 5: three full rounds so both pointers wrap
    cyc(1, 0, 0, 0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        v = 8'(8'h10 + r * 8 + i);
        cyc(0, 1, 0, 0, v);
      end
      chk("wrap_full", full5, 1'b1);
      for (int i = 0; i < 5; i++) begin
        v = 8'(8'h10 + r * 8 + i);
        pop(0, 1, 0, v);
      end
      chk("wrap_empty", empty5, 1'b1);
    end

    // Overflow at full, then simultaneous write+read at full
    cyc(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      v = 8'(8'hA0 + i);
      cyc(0, 1, 0, 0, v);
    end
    cyc(0, 1, 0, 0, 8'hAA);
    chk("ovf_set", ovf5, 1'b1);
    chk("ovf_level", lvl5, 3'd5);
    cyc(0, 1, 1, 0, 8'hBB);
    chk("wr_rd_full_level", lvl5, 3'd5);
    chk("wr_rd_full_flag", full5, 1'b1);
`ifndef SPI_FIFO_FWFT_EN
    chk("wr_rd_full_data", do5, 8'hA0);
`endif
    pop(0, 1, 0, 8'hA1);
    pop(0, 1, 0, 8'hA2);
    pop(0, 1, 0, 8'hA3);
    pop(0, 1, 0, 8'hA4);
    pop(0, 1, 0, 8'hBB);
    chk("ovf_drain_empty", empty5, 1'b1);

    // Simultaneous write+read at empty, then clear behaviour
    cyc(0, 1, 1, 0, 8'h55);
    chk("unf_set", unf5, 1'b1);
    chk("unf_level", lvl5, 3'd1);
    chk("unf_ovf_sticky", ovf5, 1'b1);
    pop(0, 1, 0, 8'h55);
    cyc(0, 0, 1, 1, 8'h00);
    chk("clr_vs_set_unf", unf5, 1'b1);
    chk("clr_vs_set_ovf", ovf5, 1'b0);
    cyc(0, 0, 0, 1, 8'h00);
    chk("clr_flags", {ovf5, unf5}, 2'b00);

    // Flush mid-stream with both requests active
    cyc(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'hC0 + i);
      cyc(0, 1, 0, 0, v);
    end
    chk("pre_flush_level", lvl8, 4'd4);
`ifndef SPI_FIFO_FWFT_EN
    chk("pre_flush_dout", do8, 8'h00);
`endif
    cyc(1, 1, 1, 0, 8'hDD);
    chk("flush_level", lvl8, 4'd0);
    chk("flush_empty", empty8, 1'b1);
    chk("flush_dout", do8, 8'h00);
    chk("flush_errs", {ovf8, unf8}, 2'b00);
    chk("flush_d5_level", lvl5, 3'd0);
    cyc(0, 1, 0, 0, 8'hE7);
    pop(1, 0, 0, 8'hE7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_fifo_lvl.md
# spi_fifo_lvl

- Parametrised synchronous FIFO for the SPI TX/RX data paths.
- Generalises the existing single-depth/width buffer with:
  - arbitrary depth (not limited to powers of two),
  - an occupancy count output,
  - programmable almost-full and almost-empty thresholds,
  - sticky overflow and underflow error flags.
- Sits between the SPI shift engine and the host-side register interface.
- Uses one clock domain; no CDC logic inside.

## Interface
- DEPTH, 8, number of entries; legal range 2..1024, any integer.
- DWIDTH, 8, data word width in bits; ≥1.
- AF_LVL, DEPTH-1, `almost_full` asserts when level ≥ AF_LVL; range 1..DEPTH.
- AE_LVL, 1, `almost_empty` asserts when level ≤ AE_LVL; range 0..DEPTH-1.

- i_clk  in  1  clock; all state updates on the rising edge.
- flush  in  1  reset/flush; one clock, reset is synchronous and active-high; clears all state.
- buff_WEn  in  1  write request.
- buff_REn  in  1  read request.
- dataIn  in  DWIDTH  write data.
- clr_err  in  1  clears the sticky error flags.
- dataOut  out  DWIDTH  read data.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_LVL.
- almost_empty  out  1  level ≤ AE_LVL.
- level  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a write was attempted while full and not accepted.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
**Storage**
- DEPTH×DWIDTH register array.
- Read and write pointers, each width $clog2(DEPTH).
- Each pointer increments on its accepted operation and wraps from DEPTH-1 to 0 by explicit compare; no power-of-two masking.
- `level` is an explicit counter, not derived from the pointers.

**Accept rules** (evaluated on pre-edge state)
- Write accepted = buff_WEn && (!full || buff_REn).
- Read accepted = buff_REn && !empty.
- A write and a read together while full are both accepted: level stays DEPTH, both pointers advance.
- A write and a read together while empty: only the write is accepted, `underflow` sets, level becomes 1.

**Level update**
- +1 on a write alone, −1 on a read alone, unchanged when both are accepted.
- Never exceeds DEPTH; never goes below 0.

**Flags**
- `full`, `empty`, `almost_full`, `almost_empty` are combinational decodes of the registered `level`.
- `overflow` sets on buff_WEn && full && !buff_REn.
- `underflow` sets on buff_REn && empty.
- Both error flags are cleared by clr_err or flush.
- If clr_err coincides with a new error event, the set wins.

**Flush**
- flush asserted has priority over all requests.
- Pointers, level, dataOut and error flags return to 0.
- Stored memory contents are not cleared.
- Requests during the flush cycle are discarded and raise no flags.
- A flush issued mid-stream drops all queued words.

## Timing
**Reset values**
- dataOut = 0, level = 0, empty = 1.
- full = 0, almost_full = 0 unless AF_LVL permits level 0 (illegal), almost_empty = 1.
- overflow = 0, underflow = 0.

**Latency**
- Write-to-visible is 1 cycle: level and flags update on the edge that accepts the write.
- Standard mode (macro absent): dataOut is registered and updates on the edge after an accepted read; it holds its value when no read is accepted.
- FWFT mode: see Configuration.

**Throughput**
- One write and one read per cycle sustained, at any fill level, including the full and empty boundaries as defined above.

## Configuration
- Macro: `SPI_FIFO_FWFT_EN`.
- Defined: first-word-fall-through.
  - dataOut shows the head entry combinationally whenever !empty, and 0 when empty.
  - An accepted read pops the entry, and the next entry appears in the same cycle after the edge.
- Undefined: standard registered read, 1-cycle read latency as in Timing.
- Flags, level, and the accept and error rules are identical in both modes.

## Test plan
- Flush, then write 0x01..0x08 with DEPTH=8 → `full`=1 and `level`=8 after the 8th edge; read 8 → data 0x01..0x08 in order, then `empty`=1.
- DEPTH=5 (non-power-of-two): 3 full write/read cycles of 5 words each → pointers wrap and data order is preserved.
- At full, write 0xAA with REn=0 → `overflow`=1, level stays 5, 0xAA is never read. At full, write plus read together → level stays 5.
- At empty, simultaneous write 0x55 and read → `underflow`=1 and level=1; next read returns 0x55. Pulse clr_err → both error flags 0.
- AF_LVL=6, AE_LVL=2, DEPTH=8: fill one by one → `almost_empty` deasserts at level 3 and `almost_full` asserts at level 6.
- Assert flush at level 4 with REn=WEn=1 → next cycle level=0, empty=1, dataOut=0, no error flags.
- Repeat all scenarios with `SPI_FIFO_FWFT_EN` defined → head word is visible with no read latency.
